// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// States, header tag and header-byte builder.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    STREAM
  } arb_state_t;

  localparam logic [3:0] HDR_TAG = 4'hA;

  function automatic logic [7:0] hdr_byte(
    input logic [3:0] id
  );
    return {HDR_TAG, id};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and TX FIFO signal bundle for the arbiter.
// slave = arbiter side, master = requesters/FIFO side.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
) ();

  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][7:0]  req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full;
  logic                  fifo_wen;
  logic [7:0]            fifo_wdata;
  logic [GW-1:0]         grant_id;
  logic                  busy;
  logic                  burst_trunc;

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  fifo_full,
    output req_ready,
    output fifo_wen,
    output fifo_wdata,
    output grant_id,
    output busy,
    output burst_trunc
  );

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output fifo_full,
    input  req_ready,
    input  fifo_wen,
    input  fifo_wdata,
    input  grant_id,
    input  busy,
    input  burst_trunc
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Circular priority encoder: first set req bit
// after position last, wrapping at NREQ.
module uart_rr_pick #(
  parameter int NREQ = 4,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [GW-1:0]   i_last,
  output logic            o_found,
  output logic [GW-1:0]   o_idx
);

  logic [GW-1:0] w_cand;

  // Scan farthest-first so the nearest hit wins.
  always_comb begin
    w_cand = '0;
    o_idx  = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_cand = GW'((int'(i_last) + i) % NREQ);
      if (i_req[w_cand]) o_idx = w_cand;
    end
  end

  assign o_found = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one TX FIFO write port
// among NREQ byte-stream requesters.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16,
  parameter int HEADER_EN = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  uart_tx_arbiter_if.slave bus
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(MAX_BURST - 1);

  arb_state_t      r_state;
  arb_state_t      w_nstate;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_last_grant;
  logic [CW-1:0]   r_cnt;
  logic            r_trunc;

  logic            w_found;
  logic [GW-1:0]   w_pick;
  logic            w_take;
  logic            w_accept;
  logic            w_release;
  logic            w_drop;
  logic            w_trunc;
  logic            w_wen;
  logic [7:0]      w_wdata;
  logic [NREQ-1:0] w_ready;
  logic [3:0]      w_id;

  uart_rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .i_req   (bus.req_valid),
    .i_last  (r_last_grant),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_id = 4'(r_grant);

  always_comb begin
    w_nstate  = r_state;
    w_take    = 1'b0;
    w_accept  = 1'b0;
    w_release = 1'b0;
    w_drop    = 1'b0;
    w_trunc   = 1'b0;
    w_wen     = 1'b0;
    w_wdata   = 8'h00;
    w_ready   = '0;
    unique case (r_state)
      IDLE: begin
        if (!flush && w_found) begin
          w_take   = 1'b1;
          w_nstate = (HEADER_EN != 0) ?
                     HEADER : STREAM;
        end
      end
      HEADER: begin
        if (flush) begin
          w_drop   = 1'b1;
          w_nstate = IDLE;
        end else if (!bus.fifo_full) begin
          w_wen    = 1'b1;
          w_wdata  = hdr_byte(w_id);
          w_nstate = STREAM;
        end
      end
      STREAM: begin
        if (flush) begin
          w_drop   = 1'b1;
          w_nstate = IDLE;
        end else begin
          w_ready[r_grant] = !bus.fifo_full;
          w_accept = bus.req_valid[r_grant] &&
                     !bus.fifo_full;
          if (w_accept) begin
            w_wen   = 1'b1;
            w_wdata = bus.req_data[r_grant];
            if (bus.req_last[r_grant] ||
                r_cnt == CNT_MAX) begin
              w_release = 1'b1;
              w_trunc   = !bus.req_last[r_grant];
              w_nstate  = IDLE;
            end
          end
        end
      end
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(NREQ - 1);
      r_cnt        <= '0;
      r_trunc      <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_trunc <= w_trunc;
      if (w_take) begin
        r_grant <= w_pick;
        r_cnt   <= '0;
      end
      if (w_release || w_drop) begin
        r_last_grant <= r_grant;
        r_cnt        <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.fifo_wen    = w_wen;
  assign bus.fifo_wdata  = w_wdata;
  assign bus.grant_id    = r_grant;
  assign bus.busy        = (r_state != IDLE);
  assign bus.burst_trunc = r_trunc;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table
// plus rotation, truncation, flush and reset sequences.
module tb_uart_tx_arbiter;

  logic clk;
  logic reset;
  logic flush;

  uart_tx_arbiter_if #(.NREQ(4)) bus ();

  uart_tx_arbiter #(
    .NREQ      (4),
    .MAX_BURST (4),
    .HEADER_EN (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic [3:0] v;
    logic [3:0] l;
    logic [7:0] d;
    logic       fu;
    logic       ew;
    logic [7:0] ed;
    logic [3:0] er;
    logic       eb;
    logic [1:0] eg;
    logic       et;
  } vec_t;

  int n_cmp;
  int n_err;

  vec_t tv[19];

  logic [7:0] md[4][8];
  logic       ml[4][8];
  int         qlen[4];
  int         qptr[4];
  logic [7:0] wr[64];
  int         wcyc[64];

  function automatic vec_t mk(
    input logic fl, input logic [3:0] v,
    input logic [3:0] l, input logic [7:0] d,
    input logic fu, input logic ew,
    input logic [7:0] ed, input logic [3:0] er,
    input logic eb, input logic [1:0] eg,
    input logic et
  );
    vec_t r;
    r.fl = fl; r.v = v; r.l = l; r.d = d;
    r.fu = fu; r.ew = ew; r.ed = ed;
    r.er = er; r.eb = eb; r.eg = eg;
    r.et = et;
    return r;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic clr_in();
    flush         = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_in();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_idle_out(input string nm);
    chk({nm, ".wen"},   32'(bus.fifo_wen), 0);
    chk({nm, ".wdata"}, 32'(bus.fifo_wdata), 0);
    chk({nm, ".ready"}, 32'(bus.req_ready), 0);
    chk({nm, ".busy"},  32'(bus.busy), 0);
    chk({nm, ".grant"}, 32'(bus.grant_id), 0);
    chk({nm, ".trunc"}, 32'(bus.burst_trunc), 0);
  endtask

  task automatic run_stream(
    input  int ncyc,
    input  int flush_at,
    output int nw,
    output int ntr,
    output int tcyc,
    output int fbad
  );
    nw = 0; ntr = 0; tcyc = -1; fbad = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (qptr[i] < qlen[i]) begin
          bus.req_valid[i] = 1'b1;
          bus.req_data[i]  = md[i][qptr[i]];
          bus.req_last[i]  = ml[i][qptr[i]];
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_data[i]  = 8'h00;
          bus.req_last[i]  = 1'b0;
        end
      end
      flush = (c == flush_at);
      #1;
      if (bus.fifo_wen && nw < 64) begin
        wr[nw]   = bus.fifo_wdata;
        wcyc[nw] = c;
        nw++;
      end
      if (bus.burst_trunc) begin
        ntr++;
        tcyc = c;
      end
      if (c == flush_at &&
          (bus.fifo_wen || bus.req_ready != 0))
        fbad = 1;
      for (int i = 0; i < 4; i++)
        if (bus.req_ready[i] && bus.req_valid[i])
          qptr[i]++;
    end
    clr_in();
  endtask

  initial begin
    int nw, ntr, tcyc, fbad;
    logic [7:0] exp_t[10];
    logic [7:0] exp_f[4];
    logic [7:0] ed;
    int m;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    clr_in();

    tv[0]  = mk(0,4'h0,4'h0,8'h00,0, 0,8'h00,4'h0,0,0,0);
    tv[1]  = mk(0,4'h4,4'h0,8'h11,0, 0,8'h00,4'h0,0,0,0);
    tv[2]  = mk(0,4'h4,4'h0,8'h11,0, 1,8'hA2,4'h0,1,2,0);
    tv[3]  = mk(0,4'h4,4'h0,8'h11,0, 1,8'h11,4'h4,1,2,0);
    tv[4]  = mk(0,4'h4,4'h0,8'h22,0, 1,8'h22,4'h4,1,2,0);
    tv[5]  = mk(0,4'h4,4'h4,8'h33,0, 1,8'h33,4'h4,1,2,0);
    tv[6]  = mk(0,4'h0,4'h0,8'h00,0, 0,8'h00,4'h0,0,2,0);
    tv[7]  = mk(0,4'h1,4'h0,8'h41,0, 0,8'h00,4'h0,0,2,0);
    tv[8]  = mk(0,4'h1,4'h0,8'h41,0, 1,8'hA0,4'h0,1,0,0);
    tv[9]  = mk(0,4'h1,4'h0,8'h41,0, 1,8'h41,4'h1,1,0,0);
    for (int k = 10; k < 15; k++)
      tv[k] = mk(0,4'h1,4'h0,8'h42,1,
                 0,8'h00,4'h0,1,0,0);
    tv[15] = mk(0,4'h1,4'h0,8'h42,0, 1,8'h42,4'h1,1,0,0);
    tv[16] = mk(0,4'h1,4'h0,8'h43,0, 1,8'h43,4'h1,1,0,0);
    tv[17] = mk(0,4'h1,4'h1,8'h44,0, 1,8'h44,4'h1,1,0,0);
    tv[18] = mk(0,4'h0,4'h0,8'h00,0, 0,8'h00,4'h0,0,0,0);

    #2;
    chk_idle_out("rst_hold");
    do_reset();

    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      flush         = tv[k].fl;
      bus.req_valid = tv[k].v;
      bus.req_last  = tv[k].l;
      bus.fifo_full = tv[k].fu;
      for (int i = 0; i < 4; i++)
        bus.req_data[i] = tv[k].v[i] ?
          tv[k].d : (8'hE0 | 8'(i));
      #1;
      chk($sformatf("v%0d.wen", k),
          32'(bus.fifo_wen), 32'(tv[k].ew));
      chk($sformatf("v%0d.wdata", k),
          32'(bus.fifo_wdata), 32'(tv[k].ed));
      chk($sformatf("v%0d.ready", k),
          32'(bus.req_ready), 32'(tv[k].er));
      chk($sformatf("v%0d.busy", k),
          32'(bus.busy), 32'(tv[k].eb));
      chk($sformatf("v%0d.grant", k),
          32'(bus.grant_id), 32'(tv[k].eg));
      chk($sformatf("v%0d.trunc", k),
          32'(bus.burst_trunc), 32'(tv[k].et));
    end

    do_reset();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      bus.req_valid = 4'hF;
      bus.req_last  = 4'hF;
      for (int i = 0; i < 4; i++)
        bus.req_data[i] = 8'h10 + 8'(i);
      #1;
      m = (c / 3) % 4;
      if (c % 3 == 1)      ed = 8'hA0 | 8'(m);
      else if (c % 3 == 2) ed = 8'h10 + 8'(m);
      else                 ed = 8'h00;
      chk($sformatf("rot%0d.wen", c),
          32'(bus.fifo_wen), 32'(c % 3 != 0));
      chk($sformatf("rot%0d.wdata", c),
          32'(bus.fifo_wdata), 32'(ed));
      chk($sformatf("rot%0d.busy", c),
          32'(bus.busy), 32'(c % 3 != 0));
    end
    clr_in();

    do_reset();
    qlen = '{0, 6, 0, 1};
    qptr = '{0, 0, 0, 0};
    for (int j = 0; j < 6; j++) begin
      md[1][j] = 8'hB1 + 8'(j);
      ml[1][j] = (j == 5);
    end
    md[3][0] = 8'h3C;
    ml[3][0] = 1'b1;
    exp_t = '{8'hA1, 8'hB1, 8'hB2, 8'hB3, 8'hB4,
              8'hA3, 8'h3C, 8'hA1, 8'hB5, 8'hB6};
    run_stream(20, -1, nw, ntr, tcyc, fbad);
    chk("trunc.nwrites", 32'(nw), 10);
    for (int j = 0; j < 10; j++)
      if (j < nw)
        chk($sformatf("trunc.byte%0d", j),
            32'(wr[j]), 32'(exp_t[j]));
    chk("trunc.pulses", 32'(ntr), 1);
    chk("trunc.when", 32'(tcyc),
        32'(wcyc[4] + 1));
    chk("trunc.cycle", 32'(tcyc), 6);

    do_reset();
    qlen = '{4, 0, 1, 0};
    qptr = '{0, 0, 0, 0};
    for (int j = 0; j < 4; j++) begin
      md[0][j] = 8'h51 + 8'(j);
      ml[0][j] = (j == 3);
    end
    md[2][0] = 8'h7E;
    ml[2][0] = 1'b1;
    exp_f = '{8'hA0, 8'h51, 8'hA2, 8'h7E};
    run_stream(8, 3, nw, ntr, tcyc, fbad);
    chk("flush.nwrites", 32'(nw), 4);
    for (int j = 0; j < 4; j++)
      if (j < nw)
        chk($sformatf("flush.byte%0d", j),
            32'(wr[j]), 32'(exp_f[j]));
    chk("flush.quiet", 32'(fbad), 0);
    chk("flush.trunc", 32'(ntr), 0);
    chk("flush.q0left", 32'(qptr[0]), 1);

    do_reset();
    @(negedge clk);
    bus.req_valid   = 4'h4;
    bus.req_data[2] = 8'h99;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst.pre_ready", 32'(bus.req_ready), 4);
    chk("rst.pre_wen", 32'(bus.fifo_wen), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_idle_out("rst_async");
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid   = 4'h9;
    bus.req_data[0] = 8'h01;
    bus.req_data[3] = 8'h03;
    #1;
    chk("rst.idle_wen", 32'(bus.fifo_wen), 0);
    chk("rst.idle_busy", 32'(bus.busy), 0);
    @(negedge clk);
    #1;
    chk("rst.hdr_wen", 32'(bus.fifo_wen), 1);
    chk("rst.hdr_byte", 32'(bus.fifo_wdata), 32'hA0);
    chk("rst.grant", 32'(bus.grant_id), 0);
    clr_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
